rast_pipe_stall: RTL and testbench

Parametrised, back-pressured pipeline delay line for the rasterizer datapath. Carries a WIDTH-bit payload through DEPTH register stages with per-stage valid bits, bubble collapsing, downstream stall and synchronous flush. Replaces fixed-length delay chains inside the bbox, iter, hash and sample modules. Stage counts come from the shared rasterizer parameter package.

---
 rtl/rast_pipe_stall_pkg.sv | 19 +
 rtl/rast_pipe_stall_stage.sv | 36 +++
 rtl/rast_pipe_stall.sv | 85 ++++++++
 tb/tb_rast_pipe_stall.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rast_pipe_stall_pkg.sv
// Shared rasterizer parameters: stage counts, field widths
// and the occupancy-width helper used by the delay lines.
package rast_params;

  localparam int SIGFIG = 24;
  localparam int AXIS   = 2;
  localparam int VERTS  = 3;
  localparam int COLORS = 8;

  localparam int PIPES_BOX    = 3;
  localparam int PIPES_ITER   = 2;
  localparam int PIPES_HASH   = 4;
  localparam int PIPES_SAMPLE = 2;

  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rast_pipe_stall_stage.sv
// One valid+payload register of the stalling delay line.
// Payload only loads on a valid arrival to limit toggling.
import rast_params::*;

module rast_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  input  logic             v_nxt,
  input  logic [WIDTH-1:0] d_nxt,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= 1'b0;
    end else if (clr) begin
      v <= 1'b0;
    end else if (adv) begin
      v <= v_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d <= '0;
    end else if (!clr && adv && v_nxt) begin
      d <= d_nxt;
    end
  end

endmodule

// File: rtl/rast_pipe_stall.sv
// Back-pressured delay line with bubble collapsing,
// synchronous flush and registered occupancy count.
import rast_params::*;

module rast_pipe_stall #(
  parameter int WIDTH = SIGFIG * AXIS * VERTS,
  parameter int DEPTH = PIPES_BOX,
  localparam int OW   = occ_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [OW-1:0]    occupancy
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] d [DEPTH];
  logic             in_xfer;
  logic             out_xfer;
  logic [OW-1:0]    occ_nxt;

  // A stage advances if anything from it downstream can move.
  always_comb begin
    logic a;
    a = out_ready | ~v[DEPTH-1];
    adv = '0;
    adv[DEPTH-1] = a;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      a = a | ~v[i];
      adv[i] = a;
    end
  end

  assign in_ready  = adv[0] & ~flush;
  assign out_valid = v[DEPTH-1] & ~flush;
  assign out_data  = d[DEPTH-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stg
    logic             vs;
    logic [WIDTH-1:0] ds;
    if (i == 0) begin : g_head
      assign vs = in_valid;
      assign ds = in_data;
    end else begin : g_body
      assign vs = v[i-1];
      assign ds = d[i-1];
    end
    rast_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stg (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .adv   (adv[i]),
      .v_nxt (vs),
      .d_nxt (ds),
      .v     (v[i]),
      .d     (d[i])
    );
  end

  // Transfers conserve payloads, so the count tracks popcount(v).
  always_comb begin
    occ_nxt = occupancy + OW'(in_xfer) - OW'(out_xfer);
    if (flush) occ_nxt = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
    end else begin
      occupancy <= occ_nxt;
    end
  end

endmodule

// File: tb/tb_rast_pipe_stall.sv
// Scoreboard bench for rast_pipe_stall at DEPTH=3, WIDTH=8.
module tb_rast_pipe_stall;

  localparam int W = 8;
  localparam int D = 3;

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
    bit           lat;
  } item_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   occupancy;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    n_out = 0;
  bit    lat_on = 1'b0;
  item_t exp_q[$];

  rast_pipe_stall #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .flush     (flush),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop on output transfer, push on input transfer.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("unexp_out", {24'h0, out_data}, 32'hdead);
        end else begin
          item_t it;
          it = exp_q.pop_front();
          chk("out_data", {24'h0, out_data}, {24'h0, it.data});
          if (it.lat) chk("latency", cyc - it.cyc, D);
        end
      end
      if (in_valid && in_ready) begin
        item_t it;
        it.data = in_data;
        it.cyc  = cyc;
        it.lat  = lat_on;
        exp_q.push_back(it);
      end
      if (flush) exp_q.delete();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_ov", out_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_od", out_data, 0);
    chk("rst_ir", in_ready, 1);
    tick();
    rst = 1'b0;

    // Streaming, no stall
    lat_on = 1'b1;
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      if (k >= 4) chk("str_occ", occupancy, 3);
      in_valid = 1'b1;
      in_data  = W'(k);
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    chk("str_done", occupancy, 0);
    lat_on = 1'b0;

    // Fill under stall
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h21;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("st_ov", out_valid, 1);
    chk("st_occ1", occupancy, 1);
    chk("st_ir1", in_ready, 1);
    in_valid = 1'b1;
    in_data  = 8'h22;
    tick();
    in_data  = 8'h23;
    tick();
    chk("st_occ3", occupancy, 3);
    chk("st_ir0", in_ready, 0);
    in_data = 8'h24;
    tick();
    tick();
    chk("st_hold_occ", occupancy, 3);
    chk("st_hold_ir", in_ready, 0);
    out_ready = 1'b1;
    #1;
    chk("full_ir", in_ready, 1);
    tick();
    chk("full_occ", occupancy, 3);
    in_valid = 1'b0;
    repeat (4) tick();
    chk("st_done", occupancy, 0);

    // Bubble collapse
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h31;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    in_data  = 8'h32;
    tick();
    in_valid = 1'b0;
    tick();
    chk("bub_occ", occupancy, 2);
    chk("bub_ir", in_ready, 1);
    chk("bub_ov", out_valid, 1);
    chk("bub_od", out_data, 8'h31);

    // Flush with occupancy 2 and a pending input
    in_valid  = 1'b1;
    in_data   = 8'h3f;
    out_ready = 1'b1;
    flush     = 1'b1;
    #1;
    chk("fl_ir", in_ready, 0);
    chk("fl_ov", out_valid, 0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_occ", occupancy, 0);
    chk("fl_ov2", out_valid, 0);
    repeat (4) tick();

    // Async reset mid-stream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = W'(8'h41 + k);
      tick();
    end
    in_valid = 1'b0;
    chk("rs_occ3", occupancy, 3);
    #2;
    rst   = 1'b1;
    flush = 1'b1;
    #1;
    chk("rs_ov", out_valid, 0);
    chk("rs_occ", occupancy, 0);
    tick();
    rst   = 1'b0;
    flush = 1'b0;
    n_out = 0;
    lat_on    = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h07;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("rs_nout", n_out, 1);
    chk("drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
